j1_core_param: RTL and testbench

//  Parametrised successor of the 16-bit j1 stack CPU: same instruction encoding, but generic data width and

---
 rtl/j1_core_param.sv | 218 +++++++++++++++++++++
 tb/tb_j1_core_param.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/j1_core_param.sv
// j1_core_param -- parametrised j1 stack CPU.
//   Same 16-bit instruction encoding as the classic j1, with generic data width
//   and stack depths, a ready/wait handshake on data reads, one vectored
//   interrupt and sticky stack-error flags.
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   code_addr / insn      instruction fetch address (next pc) and returned word
//   mem_addr, mem_wr,     data port: word address from T, write strobe with
//   mem_rd, mem_ready,      data N on dout, read request held until mem_ready,
//   dout, din               read data on din
//   irq / in_isr          level interrupt request / servicing-interrupt flag
//   dstk_err, rstk_err    sticky data/return stack overflow or underflow
module j1_core_param #(
   parameter int WIDTH      = 16,
   parameter int ADDRWIDTH  = 12,
   parameter int MEMWIDTH   = 14,
   parameter int DSTACKLOG2 = 4,
   parameter int RSTACKLOG2 = 4,
   parameter logic [ADDRWIDTH-1:0] IRQ_VECTOR = 12'h002
) (
   input  logic                 clk,
   input  logic                 reset,
   output logic [MEMWIDTH-1:0]  code_addr,
   input  logic [15:0]          insn,
   output logic [MEMWIDTH-1:0]  mem_addr,
   output logic                 mem_wr,
   output logic                 mem_rd,
   input  logic                 mem_ready,
   output logic [WIDTH-1:0]     dout,
   input  logic [WIDTH-1:0]     din,
   input  logic                 irq,
   output logic                 in_isr,
   output logic                 dstk_err,
   output logic                 rstk_err
);
   localparam int HALF = WIDTH / 2;
   localparam logic [DSTACKLOG2:0] DFULL = {1'b1, {DSTACKLOG2{1'b0}}};
   localparam logic [RSTACKLOG2:0] RFULL = {1'b1, {RSTACKLOG2{1'b0}}};

   typedef enum logic [1:0] {S_BOOT, S_RUN, S_WAIT} state_t;
   state_t state, state_n;

   logic [ADDRWIDTH-1:0]  pc, pc_n, pc_plus1, target;
   logic [WIDTH-1:0]      T, T_n, N, R, alu, rdata;
   logic [DSTACKLOG2-1:0] dsp, dsp_n;
   logic [RSTACKLOG2-1:0] rsp, rsp_n;
   logic [DSTACKLOG2:0]   depth;
   logic [RSTACKLOG2:0]   rdepth, isr_rdepth;
   logic [WIDTH-1:0]      dstack [2**DSTACKLOG2];
   logic [WIDTH-1:0]      rstack [2**RSTACKLOG2];

   logic is_alu, is_rd, irq_take, active, stall, commit;
   logic dpush, dpop, dwr, rpush, rpop, rwr;

   assign N        = dstack[dsp];
   assign R        = rstack[rsp];
   assign pc_plus1 = pc + ADDRWIDTH'(1);
   assign target   = insn[ADDRWIDTH-1:0];
   assign is_alu   = (insn[15:12] == 4'b0011);
   assign is_rd    = is_alu && (insn[11:8] == 4'hC);

   // The interrupt steals a RUN cycle; a stalled read always completes first.
   assign irq_take = (state == S_RUN) && irq && !in_isr;
   assign active   = ((state == S_RUN) && !irq_take) || (state == S_WAIT);
   assign stall    = active && is_rd && !mem_ready;
   assign commit   = active && !stall;

   assign mem_rd    = active && is_rd;
   assign mem_wr    = commit && is_alu && insn[5];
   assign mem_addr  = T[MEMWIDTH:1];
   assign dout      = N;
   // While stalled keep fetching the current word so insn stays valid.
   assign code_addr = MEMWIDTH'(stall ? pc : pc_n);

   always_comb begin
      alu = T;
      case (insn[11:8])
         4'h0: alu = T;
         4'h1: alu = N;
         4'h2: alu = T + N;
         4'h3: alu = T & N;
         4'h4: alu = T | N;
         4'h5: alu = T ^ N;
         4'h6: alu = ~T;
         4'h7: alu = {WIDTH{N == T}};
         4'h8: alu = {WIDTH{$signed(N) < $signed(T)}};
         4'h9: alu = {T[WIDTH-1], T[WIDTH-1:1]};
         4'hA: alu = T - WIDTH'(1);
         4'hB: alu = R;
         4'hC: alu = din;
         4'hD: alu = {T[WIDTH-2:0], 1'b0};
         4'hE: alu = {{(HALF-DSTACKLOG2-1){1'b0}}, depth,
                      {(HALF-RSTACKLOG2-1){1'b0}}, rdepth};
         4'hF: alu = {WIDTH{N < T}};
         default: alu = T;
      endcase
   end

   // Decode: next pc, next T and stack strobes. Pushed data-stack data is
   // always the old T; return-stack data is T unless a call or interrupt
   // pushes a return address.
   always_comb begin
      pc_n  = pc;
      T_n   = T;
      dpush = 1'b0;  dpop = 1'b0;  dwr = 1'b0;
      rpush = 1'b0;  rpop = 1'b0;  rwr = 1'b0;
      rdata = T;
      if (irq_take) begin
         pc_n  = IRQ_VECTOR;
         rpush = 1'b1;
         rwr   = 1'b1;
         rdata = WIDTH'(pc);
      end else if (commit) begin
         pc_n = pc_plus1;
         if (insn[15]) begin
            T_n   = WIDTH'(insn[14:0]);
            dpush = 1'b1;
            dwr   = 1'b1;
         end else if (!insn[14]) begin
            case (insn[13:12])
               2'b00: pc_n = target;
               2'b01: begin
                  if (T == '0) pc_n = target;
                  T_n  = N;
                  dpop = 1'b1;
               end
               2'b10: begin
                  pc_n  = target;
                  rpush = 1'b1;
                  rwr   = 1'b1;
                  rdata = WIDTH'(pc_plus1);
               end
               default: begin
                  T_n = alu;
                  if (insn[4]) pc_n = R[ADDRWIDTH-1:0];
                  dpush = insn[0];
                  dpop  = insn[1];
                  dwr   = insn[0] | insn[6];
                  rpush = insn[2];
                  rpop  = insn[3];
                  rwr   = insn[2] | insn[7];
               end
            endcase
         end
      end
   end

   // Pointers move by push - pop; a push+pop pair rewrites the current top.
   always_comb begin
      dsp_n = dsp;
      if (dpush && !dpop) dsp_n = dsp + DSTACKLOG2'(1);
      else if (dpop && !dpush) dsp_n = dsp - DSTACKLOG2'(1);
      rsp_n = rsp;
      if (rpush && !rpop) rsp_n = rsp + RSTACKLOG2'(1);
      else if (rpop && !rpush) rsp_n = rsp - RSTACKLOG2'(1);
   end

   always_comb begin
      state_n = state;
      case (state)
         S_BOOT:  state_n = S_RUN;
         S_RUN:   state_n = stall ? S_WAIT : S_RUN;
         S_WAIT:  state_n = mem_ready ? S_RUN : S_WAIT;
         default: state_n = S_BOOT;
      endcase
   end

   // Stack storage is plain RAM; contents are undefined after reset.
   always_ff @(posedge clk) begin
      if (dwr) dstack[dsp_n] <= T;
      if (rwr) rstack[rsp_n] <= rdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_BOOT;
         pc         <= '0;
         T          <= '0;
         dsp        <= '0;
         rsp        <= '0;
         depth      <= '0;
         rdepth     <= '0;
         isr_rdepth <= '0;
         in_isr     <= 1'b0;
         dstk_err   <= 1'b0;
         rstk_err   <= 1'b0;
      end else begin
         state <= state_n;
         pc    <= pc_n;
         T     <= T_n;
         dsp   <= dsp_n;
         rsp   <= rsp_n;
         // Depths saturate; the pointer still wraps so the CPU keeps going.
         if (dpush && !dpop) begin
            if (depth == DFULL) dstk_err <= 1'b1;
            else depth <= depth + (DSTACKLOG2+1)'(1);
         end else if (dpop && !dpush) begin
            if (depth == '0) dstk_err <= 1'b1;
            else depth <= depth - (DSTACKLOG2+1)'(1);
         end
         if (rpush && !rpop) begin
            if (rdepth == RFULL) rstk_err <= 1'b1;
            else rdepth <= rdepth + (RSTACKLOG2+1)'(1);
         end else if (rpop && !rpush) begin
            if (rdepth == '0) rstk_err <= 1'b1;
            else rdepth <= rdepth - (RSTACKLOG2+1)'(1);
         end
         // The ISR ends on the return that pops the entry the interrupt pushed.
         if (irq_take) begin
            in_isr     <= 1'b1;
            isr_rdepth <= rdepth;
         end else if (commit && is_alu && insn[4] && in_isr &&
                      (rdepth == isr_rdepth + (RSTACKLOG2+1)'(1))) begin
            in_isr <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_j1_core_param.sv
// Directed bench for j1_core_param: a 16-bit instance for control flow,
// memory handshake, interrupt and stack errors; a 32-bit instance for ALU width.
module tb_j1_core_param;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] insn = 16'h4000;
   logic        mem_ready = 1'b0;
   logic [15:0] din = '0;
   logic        irq = 1'b0;
   logic [13:0] code_addr, mem_addr;
   logic        mem_wr, mem_rd, in_isr, dstk_err, rstk_err;
   logic [15:0] dout;

   logic [15:0] w_insn = 16'h4000;
   logic [31:0] w_din = '0;
   logic [13:0] w_code_addr, w_mem_addr;
   logic        w_mem_wr, w_mem_rd, w_in_isr, w_dstk_err, w_rstk_err;
   logic [31:0] w_dout;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   j1_core_param u16 (
      .clk(clk), .reset(reset), .code_addr(code_addr), .insn(insn),
      .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_ready(mem_ready),
      .dout(dout), .din(din), .irq(irq), .in_isr(in_isr),
      .dstk_err(dstk_err), .rstk_err(rstk_err));

   j1_core_param #(.WIDTH(32)) u32 (
      .clk(clk), .reset(reset), .code_addr(w_code_addr), .insn(w_insn),
      .mem_addr(w_mem_addr), .mem_wr(w_mem_wr), .mem_rd(w_mem_rd), .mem_ready(1'b0),
      .dout(w_dout), .din(w_din), .irq(1'b0), .in_isr(w_in_isr),
      .dstk_err(w_dstk_err), .rstk_err(w_rstk_err));

   task automatic step(input logic [15:0] i);
      insn = i;
      @(posedge clk); #1;
   endtask

   task automatic wstep(input logic [15:0] i);
      w_insn = i;
      @(posedge clk); #1;
   endtask

   // Reset, then spend the BOOT cycle; both cores are left in RUN at pc 0.
   task automatic do_reset();
      reset = 1'b1; irq = 1'b0; mem_ready = 1'b0; insn = 16'h4000; w_insn = 16'h4000;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; insn = 16'h4000;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (code_addr !== 14'h0) begin fails++; $display("FAIL rst_code_addr got %h want 0", code_addr); end
      checks++; if (mem_wr !== 1'b0 || mem_rd !== 1'b0) begin fails++; $display("FAIL rst_mem got wr=%b rd=%b want 0 0", mem_wr, mem_rd); end
      checks++; if (in_isr !== 1'b0 || dstk_err !== 1'b0 || rstk_err !== 1'b0) begin fails++; $display("FAIL rst_flags got %b%b%b want 000", in_isr, dstk_err, rstk_err); end
      checks++; if (u16.T !== 16'h0 || u16.depth !== 5'd0) begin fails++; $display("FAIL rst_T got T=%h d=%0d want 0 0", u16.T, u16.depth); end
      // BOOT cycle presents a literal that must be ignored.
      reset = 1'b0; insn = 16'h8005; #1;
      checks++; if (code_addr !== 14'h0) begin fails++; $display("FAIL boot_code_addr got %h want 0", code_addr); end
      @(posedge clk); #1;
      checks++; if (u16.T !== 16'h0 || u16.depth !== 5'd0 || u16.pc !== 12'h0) begin fails++; $display("FAIL boot_ignored got T=%h d=%0d pc=%h want 0 0 0", u16.T, u16.depth, u16.pc); end
      checks++; if (code_addr !== 14'h1) begin fails++; $display("FAIL run_code_addr1 got %h want 1", code_addr); end
      @(posedge clk); #1;
      checks++; if (u16.T !== 16'h5 || u16.depth !== 5'd1) begin fails++; $display("FAIL lit5 got T=%h d=%0d want 5 1", u16.T, u16.depth); end
      insn = 16'h3200; #1;
      checks++; if (code_addr !== 14'h2) begin fails++; $display("FAIL run_code_addr2 got %h want 2", code_addr); end
      @(posedge clk); #1;
      checks++; if (u16.T !== 16'h5 || u16.depth !== 5'd1) begin fails++; $display("FAIL add got T=%h d=%0d want 5 1", u16.T, u16.depth); end
   endtask

   // Continues from test_reset: pc=2.
   task automatic test_mem_read();
      step(16'h8040);
      insn = 16'h3C00; din = 16'hBEEF;
      for (int c = 0; c < 4; c++) begin
         mem_ready = (c == 3); #1;
         checks++; if (mem_rd !== 1'b1 || mem_addr !== 14'h20) begin fails++; $display("FAIL rd_req c%0d got rd=%b addr=%h want 1 20", c, mem_rd, mem_addr); end
         checks++; if (code_addr !== ((c == 3) ? 14'h4 : 14'h3)) begin fails++; $display("FAIL rd_code_addr c%0d got %h", c, code_addr); end
         @(posedge clk); #1;
         if (c < 3) begin
            checks++; if (u16.pc !== 12'h3 || u16.T !== 16'h40) begin fails++; $display("FAIL rd_frozen c%0d got pc=%h T=%h want 3 40", c, u16.pc, u16.T); end
         end
      end
      mem_ready = 1'b0;
      checks++; if (u16.T !== 16'hBEEF || u16.pc !== 12'h4 || u16.depth !== 5'd2) begin fails++; $display("FAIL rd_done got T=%h pc=%h d=%0d want beef 4 2", u16.T, u16.pc, u16.depth); end
      insn = 16'h4000; #1;
      checks++; if (mem_rd !== 1'b0) begin fails++; $display("FAIL rd_release got %b want 0", mem_rd); end
   endtask

   task automatic test_reset_midwait();
      do_reset();
      step(16'h8040);
      insn = 16'h3C00; mem_ready = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1; #1;
      checks++; if (mem_rd !== 1'b0 || code_addr !== 14'h0 || u16.T !== 16'h0) begin fails++; $display("FAIL rst_wait got rd=%b ca=%h T=%h want 0 0 0", mem_rd, code_addr, u16.T); end
      reset = 1'b0;
   endtask

   task automatic test_branch_memwr();
      do_reset();
      step(16'h8003);
      step(16'h8000);
      insn = 16'h1050; #1;
      checks++; if (code_addr !== 14'h050) begin fails++; $display("FAIL bz_taken_addr got %h want 050", code_addr); end
      @(posedge clk); #1;
      checks++; if (u16.pc !== 12'h050 || u16.T !== 16'h3 || u16.depth !== 5'd1) begin fails++; $display("FAIL bz_taken got pc=%h T=%h d=%0d want 050 3 1", u16.pc, u16.T, u16.depth); end
      step(16'h1070);
      checks++; if (u16.pc !== 12'h051 || u16.T !== 16'h0 || u16.depth !== 5'd0) begin fails++; $display("FAIL bz_not_taken got pc=%h T=%h d=%0d want 051 0 0", u16.pc, u16.T, u16.depth); end
      step(16'h9234);
      step(16'h8080);
      insn = 16'h3022; #1;
      checks++; if (mem_wr !== 1'b1 || mem_addr !== 14'h40 || dout !== 16'h1234) begin fails++; $display("FAIL store got wr=%b a=%h d=%h want 1 40 1234", mem_wr, mem_addr, dout); end
      @(posedge clk); #1;
      insn = 16'h4000; #1;
      checks++; if (mem_wr !== 1'b0 || u16.depth !== 5'd1) begin fails++; $display("FAIL store_pulse got wr=%b d=%0d want 0 1", mem_wr, u16.depth); end
      @(posedge clk); #1;
   endtask

   task automatic test_irq();
      do_reset();
      step(16'h0010);
      irq = 1'b1; insn = 16'h2100; #1;
      checks++; if (code_addr !== 14'h002 || mem_wr !== 1'b0) begin fails++; $display("FAIL irq_vec got ca=%h wr=%b want 002 0", code_addr, mem_wr); end
      @(posedge clk); #1;
      checks++; if (u16.pc !== 12'h002 || in_isr !== 1'b1 || u16.R[11:0] !== 12'h010 || u16.rdepth !== 5'd1) begin fails++; $display("FAIL irq_entry got pc=%h isr=%b R=%h rd=%0d want 002 1 010 1", u16.pc, in_isr, u16.R, u16.rdepth); end
      checks++; if (u16.T !== 16'h0 || u16.depth !== 5'd0) begin fails++; $display("FAIL irq_discard got T=%h d=%0d want 0 0", u16.T, u16.depth); end
      step(16'h2030);
      checks++; if (u16.pc !== 12'h030 || u16.rdepth !== 5'd2 || in_isr !== 1'b1) begin fails++; $display("FAIL isr_call got pc=%h rd=%0d isr=%b want 030 2 1", u16.pc, u16.rdepth, in_isr); end
      step(16'h3018);
      checks++; if (u16.pc !== 12'h003 || in_isr !== 1'b1 || u16.rdepth !== 5'd1) begin fails++; $display("FAIL isr_nested_ret got pc=%h isr=%b rd=%0d want 003 1 1", u16.pc, in_isr, u16.rdepth); end
      irq = 1'b0;
      step(16'h3018);
      checks++; if (u16.pc !== 12'h010 || in_isr !== 1'b0 || u16.rdepth !== 5'd0) begin fails++; $display("FAIL isr_ret got pc=%h isr=%b rd=%0d want 010 0 0", u16.pc, in_isr, u16.rdepth); end
      step(16'h2100);
      checks++; if (u16.pc !== 12'h100 || u16.R[11:0] !== 12'h011 || u16.rdepth !== 5'd1) begin fails++; $display("FAIL reexec_call got pc=%h R=%h rd=%0d want 100 011 1", u16.pc, u16.R, u16.rdepth); end
   endtask

   task automatic test_stack_errors();
      do_reset();
      for (int i = 0; i < 17; i++) begin
         step(16'h8000 | 16'(i));
         if (i < 16) begin
            checks++; if (dstk_err !== 1'b0 || u16.depth !== 5'(i + 1)) begin fails++; $display("FAIL push%0d got err=%b d=%0d want 0 %0d", i, dstk_err, u16.depth, i + 1); end
         end else begin
            checks++; if (dstk_err !== 1'b1 || u16.depth !== 5'd16) begin fails++; $display("FAIL push_ovf got err=%b d=%0d want 1 16", dstk_err, u16.depth); end
         end
      end
      step(16'h4000); step(16'h4000);
      checks++; if (dstk_err !== 1'b1 || rstk_err !== 1'b0) begin fails++; $display("FAIL ovf_sticky got d=%b r=%b want 1 0", dstk_err, rstk_err); end
      step(16'h3008);
      checks++; if (rstk_err !== 1'b1 || u16.rdepth !== 5'd0) begin fails++; $display("FAIL rpop_empty got err=%b rd=%0d want 1 0", rstk_err, u16.rdepth); end
      do_reset();
      checks++; if (dstk_err !== 1'b0 || rstk_err !== 1'b0) begin fails++; $display("FAIL err_clear got d=%b r=%b want 0 0", dstk_err, rstk_err); end
      step(16'h3002);
      checks++; if (dstk_err !== 1'b1 || u16.depth !== 5'd0) begin fails++; $display("FAIL dpop_empty got err=%b d=%0d want 1 0", dstk_err, u16.depth); end
   endtask

   task automatic test_width32();
      do_reset();
      wstep(16'hFFFF);
      checks++; if (u32.T !== 32'h00007FFF) begin fails++; $display("FAIL w_lit got %h want 00007fff", u32.T); end
      wstep(16'h3D00);
      checks++; if (u32.T !== 32'h0000FFFE) begin fails++; $display("FAIL w_shl got %h want 0000fffe", u32.T); end
      wstep(16'h8000);
      wstep(16'h3A00);
      checks++; if (u32.T !== 32'hFFFFFFFF) begin fails++; $display("FAIL w_dec got %h want ffffffff", u32.T); end
      wstep(16'h3F00);
      checks++; if (u32.T !== 32'hFFFFFFFF) begin fails++; $display("FAIL w_ult got %h want ffffffff", u32.T); end
      wstep(16'h3800);
      checks++; if (u32.T !== 32'h00000000) begin fails++; $display("FAIL w_slt got %h want 00000000", u32.T); end
      wstep(16'h3A00);
      wstep(16'h3900);
      checks++; if (u32.T !== 32'hFFFFFFFF) begin fails++; $display("FAIL w_sar got %h want ffffffff", u32.T); end
      wstep(16'h3E00);
      checks++; if (u32.T !== 32'h00020000) begin fails++; $display("FAIL w_depth got %h want 00020000", u32.T); end
   endtask

   initial begin
      test_reset();
      test_mem_read();
      test_reset_midwait();
      test_branch_memwr();
      test_irq();
      test_stack_errors();
      test_width32();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout reached without completing the sequence");
      $fatal(1);
   end
endmodule
